// File: rtl/ysyx_23060201_mem_arbiter_pkg.sv
// Shared types and constants for the IFU/LSU memory arbiter.
package ysyx_23060201_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  localparam logic M_IFU = 1'b0;
  localparam logic M_LSU = 1'b1;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/ysyx_23060201_rr_arb2.sv
// Two-input grant logic: round-robin on last grant, or fixed LSU-first priority.
module ysyx_23060201_rr_arb2
  import ysyx_23060201_mem_arbiter_pkg::*;
#(
  parameter bit RR = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_ifu,
  input  logic req_lsu,
  input  logic accept,
  output logic gnt_ifu,
  output logic gnt_lsu,
  output logic gnt_id
);

  logic last_q, last_d;
  logic winner;

  always_comb begin
    winner = M_LSU;
    if (req_ifu && !req_lsu) begin
      winner = M_IFU;
    end else if (req_ifu && req_lsu && RR && (last_q == M_LSU)) begin
      winner = M_IFU;
    end
    gnt_ifu = req_ifu && (winner == M_IFU);
    gnt_lsu = req_lsu && (winner == M_LSU);
    gnt_id  = winner;
    last_d  = accept ? winner : last_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= M_IFU;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/ysyx_23060201_mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between IFU and LSU,
// with a bounded memory wait that returns an error response.
module ysyx_23060201_mem_arbiter
  import ysyx_23060201_mem_arbiter_pkg::*;
#(
  parameter int unsigned RR       = 1,
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_addr,
  output logic        ifu_rsp_valid,
  input  logic        ifu_rsp_ready,
  output logic [31:0] ifu_rsp_data,
  output logic        ifu_rsp_err,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [31:0] lsu_addr,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wmask,
  output logic        lsu_rsp_valid,
  input  logic        lsu_rsp_ready,
  output logic [31:0] lsu_rsp_data,
  output logic        lsu_rsp_err,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_rsp_valid,
  output logic        mem_rsp_ready,
  input  logic [31:0] mem_rsp_data
);

  localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

  state_e             state_q, state_d;
  logic               grant_q, grant_d;
  logic [31:0]        addr_q, addr_d;
  logic               wen_q, wen_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         wmask_q, wmask_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic gnt_ifu, gnt_lsu, gnt_id;
  logic in_idle, accept, timeout_hit, rsp_taken;

  // Gating with rst keeps req_ready low while reset is held, even if a requester is valid.
  assign in_idle = rst && (state_q == IDLE);
  assign accept  = in_idle && (gnt_ifu || gnt_lsu);

  ysyx_23060201_rr_arb2 #(
    .RR(RR != 0)
  ) u_arb (
    .clk    (clk),
    .rst_n  (rst),
    .req_ifu(ifu_req_valid),
    .req_lsu(lsu_req_valid),
    .accept (accept),
    .gnt_ifu(gnt_ifu),
    .gnt_lsu(gnt_lsu),
    .gnt_id (gnt_id)
  );

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));
  assign rsp_taken   = (grant_q == M_IFU) ? ifu_rsp_ready : lsu_rsp_ready;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    wen_d   = wen_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          grant_d = gnt_id;
          state_d = ISSUE;
          if (gnt_id == M_LSU) begin
            addr_d  = lsu_addr;
            wen_d   = lsu_wen;
            wdata_d = lsu_wdata;
            wmask_d = lsu_wmask;
          end else begin
            addr_d  = ifu_addr;
            wen_d   = 1'b0;
            wdata_d = '0;
            wmask_d = '0;
          end
        end
      end
      ISSUE: begin
        if (mem_req_ready) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        if (mem_rsp_valid) begin
          rdata_d = mem_rsp_data;
          err_d   = 1'b0;
          state_d = RESP;
        end else begin
          cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
          if (timeout_hit) begin
            rdata_d = ERR_DATA;
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      RESP: begin
        if (rsp_taken) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= M_IFU;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ifu_req_ready = in_idle && gnt_ifu;
  assign lsu_req_ready = in_idle && gnt_lsu;

  assign mem_req_valid = (state_q == ISSUE);
  assign mem_addr      = addr_q;
  assign mem_wen       = wen_q;
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;
  assign mem_rsp_ready = (state_q == WAIT);

  assign ifu_rsp_valid = (state_q == RESP) && (grant_q == M_IFU);
  assign lsu_rsp_valid = (state_q == RESP) && (grant_q == M_LSU);
  assign ifu_rsp_data  = rdata_q;
  assign lsu_rsp_data  = rdata_q;
  assign ifu_rsp_err   = ifu_rsp_valid && err_q;
  assign lsu_rsp_err   = lsu_rsp_valid && err_q;

endmodule

// File: tb/tb_ysyx_23060201_mem_arbiter.sv
// Directed bench for the memory arbiter with a transaction-level reference model.
module tb_ysyx_23060201_mem_arbiter;

  localparam bit B_IFU  = 1'b0;
  localparam bit B_LSU  = 1'b1;
  localparam bit TB_RR  = 1'b1;
  localparam int TB_TMO = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic        ifu_req_valid = 1'b0, ifu_rsp_ready = 1'b1;
  logic [31:0] ifu_addr = '0;
  logic        lsu_req_valid = 1'b0, lsu_wen = 1'b0, lsu_rsp_ready = 1'b1;
  logic [31:0] lsu_addr = '0, lsu_wdata = '0;
  logic [3:0]  lsu_wmask = '0;
  logic        mem_req_ready = 1'b0, mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;
  logic        ifu_req_ready, ifu_rsp_valid, ifu_rsp_err;
  logic [31:0] ifu_rsp_data;
  logic        lsu_req_ready, lsu_rsp_valid, lsu_rsp_err;
  logic [31:0] lsu_rsp_data;
  logic        mem_req_valid, mem_wen, mem_rsp_ready;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;

  logic        f_ifu_req_valid = 1'b0, f_lsu_req_valid = 1'b0;
  logic        f_ifu_req_ready, f_lsu_req_ready, f_ifu_rsp_valid, f_lsu_rsp_valid;
  logic        f_ifu_rsp_err, f_lsu_rsp_err, f_mem_req_valid, f_mem_wen, f_mem_rsp_ready;
  logic [31:0] f_ifu_rsp_data, f_lsu_rsp_data, f_mem_addr, f_mem_wdata;
  logic [3:0]  f_mem_wmask;
  logic        f_mem_rsp_valid;
  assign f_mem_rsp_valid = f_mem_rsp_ready;

  ysyx_23060201_mem_arbiter #(.RR(1), .TIMEOUT(TB_TMO)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready),
    .ifu_rsp_data(ifu_rsp_data), .ifu_rsp_err(ifu_rsp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready),
    .lsu_rsp_data(lsu_rsp_data), .lsu_rsp_err(lsu_rsp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready), .mem_rsp_data(mem_rsp_data)
  );

  ysyx_23060201_mem_arbiter #(.RR(0), .TIMEOUT(TB_TMO)) fx (
    .clk(clk), .rst(rst),
    .ifu_req_valid(f_ifu_req_valid), .ifu_req_ready(f_ifu_req_ready), .ifu_addr(32'h8000_2000),
    .ifu_rsp_valid(f_ifu_rsp_valid), .ifu_rsp_ready(1'b1),
    .ifu_rsp_data(f_ifu_rsp_data), .ifu_rsp_err(f_ifu_rsp_err),
    .lsu_req_valid(f_lsu_req_valid), .lsu_req_ready(f_lsu_req_ready), .lsu_addr(32'h8000_3000),
    .lsu_wen(1'b0), .lsu_wdata(32'h0), .lsu_wmask(4'h0),
    .lsu_rsp_valid(f_lsu_rsp_valid), .lsu_rsp_ready(1'b1),
    .lsu_rsp_data(f_lsu_rsp_data), .lsu_rsp_err(f_lsu_rsp_err),
    .mem_req_valid(f_mem_req_valid), .mem_req_ready(1'b1), .mem_addr(f_mem_addr),
    .mem_wen(f_mem_wen), .mem_wdata(f_mem_wdata), .mem_wmask(f_mem_wmask),
    .mem_rsp_valid(f_mem_rsp_valid), .mem_rsp_ready(f_mem_rsp_ready), .mem_rsp_data(32'h1111_2222)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: one transaction record with its progress flags.
  bit          m_busy = 0, m_issued = 0, m_answered = 0, m_who = 0, m_last = B_IFU;
  bit          m_err = 0, m_wen = 0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_data = '0;
  logic [3:0]  m_wmask = '0;
  int          m_waited = 0;

  function automatic bit pick(input bit iv, input bit lv, input bit last);
    if (iv && !lv) return B_IFU;
    if (lv && !iv) return B_LSU;
    if (TB_RR) return (last == B_IFU) ? B_LSU : B_IFU;
    return B_LSU;
  endfunction

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_busy = 0; m_issued = 0; m_answered = 0; m_last = B_IFU; m_waited = 0;
    end else if (!m_busy) begin
      if (ifu_req_valid || lsu_req_valid) begin
        m_who = pick(ifu_req_valid, lsu_req_valid, m_last);
        m_last = m_who;
        m_busy = 1; m_issued = 0; m_answered = 0;
        if (m_who == B_LSU) begin
          m_addr = lsu_addr; m_wen = lsu_wen; m_wdata = lsu_wdata; m_wmask = lsu_wmask;
        end else begin
          m_addr = ifu_addr; m_wen = 0; m_wdata = '0; m_wmask = '0;
        end
      end
    end else if (!m_issued) begin
      if (mem_req_ready) begin m_issued = 1; m_waited = 0; end
    end else if (!m_answered) begin
      if (mem_rsp_valid) begin
        m_answered = 1; m_data = mem_rsp_data; m_err = 0;
      end else begin
        m_waited++;
        if (TB_TMO != 0 && m_waited == TB_TMO) begin
          m_answered = 1; m_data = 32'hDEAD_BEEF; m_err = 1;
        end
      end
    end else if ((m_who == B_IFU) ? ifu_rsp_ready : lsu_rsp_ready) begin
      m_busy = 0;
    end
  end

  function automatic logic any_out();
    return |{ifu_req_ready, ifu_rsp_valid, ifu_rsp_data, ifu_rsp_err,
             lsu_req_ready, lsu_rsp_valid, lsu_rsp_data, lsu_rsp_err,
             mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask, mem_rsp_ready};
  endfunction

  // Per-cycle comparison against the model.
  initial forever begin
    bit w;
    @(negedge clk);
    if (!rst) begin
      chk("reset_outputs", any_out(), 1'b0);
    end else begin
      w = pick(ifu_req_valid, lsu_req_valid, m_last);
      chk("ifu_req_ready", ifu_req_ready, !m_busy && ifu_req_valid && w == B_IFU);
      chk("lsu_req_ready", lsu_req_ready, !m_busy && lsu_req_valid && w == B_LSU);
      chk("mem_req_valid", mem_req_valid, m_busy && !m_issued);
      chk("mem_rsp_ready", mem_rsp_ready, m_busy && m_issued && !m_answered);
      chk("ifu_rsp_valid", ifu_rsp_valid, m_busy && m_answered && m_who == B_IFU);
      chk("lsu_rsp_valid", lsu_rsp_valid, m_busy && m_answered && m_who == B_LSU);
      if (m_busy && !m_issued) begin
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_wen", mem_wen, m_wen);
        chk("mem_wmask", mem_wmask, m_wmask);
        if (m_wen) chk("mem_wdata", mem_wdata, m_wdata);
      end
      if (m_busy && m_answered && m_who == B_IFU) begin
        chk("ifu_rsp_data", ifu_rsp_data, m_data);
        chk("ifu_rsp_err", ifu_rsp_err, m_err);
      end
      if (m_busy && m_answered && m_who == B_LSU) begin
        chk("lsu_rsp_data", lsu_rsp_data, m_data);
        chk("lsu_rsp_err", lsu_rsp_err, m_err);
      end
    end
  end

  // Monitor: handshake flags and event counters for directed checks.
  int cyc = 0, ifu_acc = -1, lsu_acc = -1, ifu_first = -1, ifu_take = -1;
  int ifu_rsp_cycles = 0, lsu_rsp_cycles = 0, mem_req_cycles = 0, mem_rsp_rdy_cycles = 0;
  int f_ifu_hs = 0, f_lsu_hs = 0;
  bit ifu_hs = 0, lsu_hs = 0, both_rdy = 0, f_both = 0;
  logic [31:0] ifu_cap_data = '0, lsu_cap_data = '0, cap_addr = '0, cap_wdata = '0;
  logic        ifu_cap_err = 0, lsu_cap_err = 0, cap_wen = 0;
  logic [3:0]  cap_wmask = '0;

  initial forever begin
    @(negedge clk);
    cyc++;
    ifu_hs = rst && ifu_req_valid && ifu_req_ready;
    lsu_hs = rst && lsu_req_valid && lsu_req_ready;
    if (rst) begin
      if (ifu_hs) ifu_acc = cyc;
      if (lsu_hs) lsu_acc = cyc;
      if (ifu_req_ready && lsu_req_ready) both_rdy = 1;
      if (ifu_rsp_valid) begin
        ifu_rsp_cycles++;
        if (ifu_first < 0) ifu_first = cyc;
        if (ifu_rsp_ready) begin ifu_take = cyc; ifu_cap_data = ifu_rsp_data; ifu_cap_err = ifu_rsp_err; end
      end
      if (lsu_rsp_valid) begin
        lsu_rsp_cycles++;
        if (lsu_rsp_ready) begin lsu_cap_data = lsu_rsp_data; lsu_cap_err = lsu_rsp_err; end
      end
      if (mem_req_valid) begin
        mem_req_cycles++;
        if (mem_req_ready) begin
          cap_addr = mem_addr; cap_wen = mem_wen; cap_wdata = mem_wdata; cap_wmask = mem_wmask;
        end
      end
      if (mem_rsp_ready) mem_rsp_rdy_cycles++;
      if (f_ifu_req_valid && f_ifu_req_ready) f_ifu_hs++;
      if (f_lsu_req_valid && f_lsu_req_ready) f_lsu_hs++;
      if (f_ifu_req_ready && f_lsu_req_ready) f_both = 1;
    end
  end

  // Requester agents: issue todo requests at consecutive word addresses.
  int ifu_todo = 0, lsu_todo = 0, ifu_n = 0, lsu_n = 0;
  logic [31:0] ifu_base = '0, lsu_base = '0;
  logic        lsu_wen_t = 0;
  logic [31:0] lsu_wdata_t = '0;
  logic [3:0]  lsu_wmask_t = '0;
  bit grant_log[$];

  initial forever begin
    @(posedge clk); #1;
    if (ifu_hs) begin ifu_todo--; ifu_n++; grant_log.push_back(B_IFU); end
    if (lsu_hs) begin lsu_todo--; lsu_n++; grant_log.push_back(B_LSU); end
    ifu_req_valid = (ifu_todo > 0);
    ifu_addr = ifu_base + 32'(ifu_n * 4);
    lsu_req_valid = (lsu_todo > 0);
    lsu_addr = lsu_base + 32'(lsu_n * 4);
    lsu_wen = lsu_wen_t; lsu_wdata = lsu_wdata_t; lsu_wmask = lsu_wmask_t;
  end

  // Memory responder.
  int ready_delay = 0, rsp_delay = 0, icnt = 0, wcnt = 0;
  bit no_answer = 0, late_rsp = 0;
  logic [31:0] rsp_word = '0;

  initial forever begin
    @(posedge clk); #1;
    if (mem_req_valid) begin mem_req_ready = (icnt == ready_delay); icnt++; end
    else begin mem_req_ready = 0; icnt = 0; end
    mem_rsp_data = rsp_word;
    if (mem_rsp_ready) begin mem_rsp_valid = !no_answer && (wcnt == rsp_delay); wcnt++; end
    else begin mem_rsp_valid = late_rsp; wcnt = 0; end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic wait_done(input string tag);
    bit ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      step();
      if (ifu_todo == 0 && lsu_todo == 0 && !m_busy) ok = 1;
    end
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL %s: transactions not finished, got busy, expected idle", tag); end
  endtask

  initial begin
    bit seen;
    repeat (3) step();
    chk("reset_literal", any_out(), 1'b0);
    rst = 1;
    step();

    // Round-robin from reset: LSU wins the first tie.
    grant_log.delete(); both_rdy = 0; rsp_word = 32'h0000_0001;
    ifu_base = 32'h8000_1000; ifu_n = 0; lsu_base = 32'h8000_0400; lsu_n = 0;
    ifu_todo = 2; lsu_todo = 2;
    wait_done("rr");
    chk("rr_count", grant_log.size(), 4);
    if (grant_log.size() == 4) begin
      chk("rr_g0", grant_log[0], B_LSU);
      chk("rr_g1", grant_log[1], B_IFU);
      chk("rr_g2", grant_log[2], B_LSU);
      chk("rr_g3", grant_log[3], B_IFU);
    end
    chk("rr_both_ready", both_rdy, 0);

    // IFU read, zero-wait memory.
    rsp_word = 32'h0000_0413; ifu_base = 32'h8000_0000; ifu_n = 0;
    ifu_first = -1; ifu_acc = -1; ifu_rsp_cycles = 0; lsu_rsp_cycles = 0;
    ifu_todo = 1;
    wait_done("ifu_read");
    chk("ifu_latency", ifu_first - ifu_acc, 3);
    chk("ifu_data", ifu_cap_data, 32'h0000_0413);
    chk("ifu_err", ifu_cap_err, 0);
    chk("ifu_rsp_cycles", ifu_rsp_cycles, 1);
    chk("ifu_no_lsu_rsp", lsu_rsp_cycles, 0);

    // LSU store, memory holds off acceptance for 3 cycles.
    rsp_word = 32'hCAFE_0001; ready_delay = 3;
    lsu_base = 32'h8000_0100; lsu_n = 0;
    lsu_wen_t = 1; lsu_wdata_t = 32'h1234_5678; lsu_wmask_t = 4'b0011;
    mem_req_cycles = 0; lsu_rsp_cycles = 0;
    lsu_todo = 1;
    wait_done("store");
    ready_delay = 0; lsu_wen_t = 0; lsu_wmask_t = '0;
    chk("st_req_cycles", mem_req_cycles, 4);
    chk("st_addr", cap_addr, 32'h8000_0100);
    chk("st_wen", cap_wen, 1);
    chk("st_wdata", cap_wdata, 32'h1234_5678);
    chk("st_wmask", cap_wmask, 4'b0011);
    chk("st_rsp_cycles", lsu_rsp_cycles, 1);
    chk("st_rsp_data", lsu_cap_data, 32'hCAFE_0001);

    // IFU consumer backpressure with an LSU request waiting behind it.
    rsp_word = 32'h0000_0093; ifu_base = 32'h8000_0004; ifu_n = 0;
    lsu_base = 32'h8000_0300; lsu_n = 0;
    ifu_rsp_cycles = 0; ifu_rsp_ready = 0;
    ifu_todo = 1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin step(); if (ifu_rsp_valid) seen = 1; end
    chk("bp_rsp_seen", seen, 1);
    lsu_todo = 1;
    repeat (5) step();
    ifu_rsp_ready = 1;
    wait_done("backpressure");
    chk("bp_rsp_cycles", ifu_rsp_cycles, 6);
    chk("bp_data", ifu_cap_data, 32'h0000_0093);
    chk("bp_lsu_after", lsu_acc - ifu_take, 1);

    // Memory never answers: timeout error after 8 wait cycles.
    no_answer = 1; lsu_base = 32'h8000_0200; lsu_n = 0; mem_rsp_rdy_cycles = 0;
    lsu_todo = 1;
    wait_done("timeout");
    no_answer = 0;
    chk("to_wait_cycles", mem_rsp_rdy_cycles, 8);
    chk("to_data", lsu_cap_data, 32'hDEAD_BEEF);
    chk("to_err", lsu_cap_err, 1);
    lsu_rsp_cycles = 0; ifu_rsp_cycles = 0; late_rsp = 1;
    repeat (4) step();
    late_rsp = 0;
    chk("late_no_lsu_rsp", lsu_rsp_cycles, 0);
    chk("late_no_ifu_rsp", ifu_rsp_cycles, 0);

    // Reset asserted during WAIT.
    no_answer = 1; lsu_base = 32'h8000_0500; lsu_n = 0;
    lsu_todo = 1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin step(); if (mem_rsp_ready) seen = 1; end
    chk("rst_wait_seen", seen, 1);
    step();
    lsu_rsp_cycles = 0;
    rst = 0;
    #1;
    chk("rst_async_zero", any_out(), 1'b0);
    grant_log.delete();
    ifu_base = 32'h8000_0600; ifu_n = 0; lsu_n = 0;
    ifu_todo = 1; lsu_todo = 1;
    repeat (3) step();
    chk("rst_valids_held", {ifu_req_valid, lsu_req_valid}, 2'b11);
    chk("rst_ready_low", {ifu_req_ready, lsu_req_ready}, 2'b00);
    no_answer = 0;
    rst = 1;
    wait_done("after_reset");
    chk("rst_no_rsp", lsu_rsp_cycles, 1);
    chk("rst_grant_count", grant_log.size(), 2);
    if (grant_log.size() > 0) chk("rst_first_grant", grant_log[0], B_LSU);

    // Fixed-priority instance: LSU always wins while valid.
    step();
    f_ifu_hs = 0; f_lsu_hs = 0; f_both = 0;
    f_ifu_req_valid = 1; f_lsu_req_valid = 1;
    repeat (16) step();
    f_ifu_req_valid = 0; f_lsu_req_valid = 0;
    repeat (4) step();
    chk("fx_ifu_grants", f_ifu_hs, 0);
    chk("fx_lsu_grants", f_lsu_hs, 4);
    chk("fx_both_ready", f_both, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_23060201_mem_arbiter.md
Name: ysyx_23060201_mem_arbiter

Overview:
- Single-outstanding arbiter that shares one memory port between two requesters: instruction fetch (IFU, read-only) and load/store (LSU, read/write).
- Sits between the fetch/LSU stages and the memory model. It replaces the direct combinational PC-to-MEM read path once the core goes multi-cycle.
- Sequences each transaction through request, memory wait and response phases. It has a bounded-wait timeout that returns an error response.

Parameters:
- RR, 1, arbitration mode: 1 = round-robin between IFU and LSU; 0 = fixed priority, LSU first.
- TIMEOUT, 255, maximum WAIT cycles before an error response is forced; 0 disables the timeout.
- ERR_DATA, 32'hDEAD_BEEF, rsp_data value returned on a timeout.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-low (asserted at 0)
- ifu_req_valid  in  1  IFU read request
- ifu_req_ready  out  1  IFU request accepted
- ifu_addr  in  32  IFU fetch address
- ifu_rsp_valid  out  1  IFU response valid
- ifu_rsp_ready  in  1  IFU takes response
- ifu_rsp_data  out  32  fetched instruction
- ifu_rsp_err  out  1  IFU response is a timeout error
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted
- lsu_addr  in  32  LSU address
- lsu_wen  in  1  1 = store, 0 = load
- lsu_wdata  in  32  store data
- lsu_wmask  in  4  store byte mask
- lsu_rsp_valid  out  1  LSU response valid
- lsu_rsp_ready  in  1  LSU takes response
- lsu_rsp_data  out  32  load data
- lsu_rsp_err  out  1  LSU response is a timeout error
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  32  memory address
- mem_wen  out  1  memory write enable
- mem_wdata  out  32  memory write data
- mem_wmask  out  4  memory byte mask
- mem_rsp_valid  in  1  memory response valid
- mem_rsp_ready  out  1  arbiter accepts memory response
- mem_rsp_data  in  32  memory read data

Behaviour:
- Reset values:
  - State is IDLE and all outputs are 0.
  - last_grant = IFU, so LSU wins the first tie in RR mode.
  - The timeout counter is 0.
- Reset mid-transaction aborts the transaction immediately; no response is ever delivered for it.
- IDLE:
  - The winner's req_ready = 1 combinationally; the loser's req_ready = 0.
  - At most one req_ready is high per cycle.
  - When valid & ready, the arbiter latches addr, wen, wdata and wmask (IFU forces wen = 0, wmask = 0), records grant, and moves to ISSUE.
- Arbitration:
  - Only one requester valid: it wins.
  - Both valid, RR = 1: the requester not equal to last_grant wins. last_grant updates on acceptance.
  - Both valid, RR = 0: LSU wins.
- ISSUE:
  - mem_req_valid = 1 with the latched fields held stable.
  - On mem_req_ready, move to WAIT and clear the counter.
- WAIT:
  - mem_rsp_ready = 1.
  - On mem_rsp_valid, latch mem_rsp_data, set err = 0, and move to RESP.
  - Otherwise the counter increments. If TIMEOUT != 0 and counter == TIMEOUT-1, latch ERR_DATA, set err = 1, and move to RESP.
- RESP:
  - The granted master's rsp_valid = 1, with data and err held stable.
  - On that master's rsp_ready, return to IDLE. A new request is accepted in the following cycle, not the same cycle.
- Store responses forward mem_rsp_data unchanged.
- Memory responses outside WAIT are ignored (mem_rsp_ready = 0).
- req_ready is 0 in every state except IDLE. Requesters must hold valid and payload until accepted.
- Minimum latency, with zero-wait memory and ready consumer:
  - acceptance edge E0, ISSUE cycle, WAIT cycle, rsp_valid high in the cycle after E2;
  - throughput is 1 transaction per 4 cycles.
- The counter width is clog2(TIMEOUT+1) and it saturates (never wraps).

Decomposition:
- Shared package holds:
  - state enum: IDLE, ISSUE, WAIT, RESP;
  - master id constants: M_IFU = 0, M_LSU = 1;
  - ERR_DATA default.
- One sub-module, ysyx_23060201_rr_arb2: 2-input grant logic with a last_grant register and RR/fixed mode select. The FSM, payload registers and timeout counter stay in the top.

Test Plan:
- IFU-only read, addr 0x8000_0000, memory returns 0x0000_0413 after 0 waits -> ifu_rsp_valid exactly 3 cycles after acceptance, data 0x0000_0413, err 0, lsu_rsp_valid never high.
- LSU store, addr 0x8000_0100, wdata 0x1234_5678, wmask 4'b0011 -> mem_wen = 1, mem_wmask = 4'b0011, mem_addr/wdata stable while mem_req_ready held low 3 cycles, single lsu_rsp_valid pulse.
- RR = 1, both requesting continuously after reset -> grant order LSU, IFU, LSU, IFU; never two req_ready high together. RR = 0 -> LSU granted every time while valid.
- TIMEOUT = 8, memory never answers -> lsu_rsp_valid asserted after 8 WAIT cycles with data 0xDEAD_BEEF, err 1. A late mem_rsp_valid after return to IDLE produces no response.
- Consumer backpressure: ifu_rsp_ready low 5 cycles -> rsp_valid, data and err held constant, no new req_ready during RESP.
- rst driven low during WAIT -> all outputs 0 asynchronously, no response delivered. After release, the first tie is granted to LSU.
